// File: rtl/alu.sv
// alu: RV32 base/M-extension execute unit with single-cycle base ops, two-cycle multiply and 32-step divide
module alu #(
  parameter int OP_W = 4,
  parameter int ROB_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             need_flush_in,
  input  logic             rs2alu_ready,
  input  logic [OP_W-1:0]  rs2alu_op_L1,
  input  logic             rs2alu_op_L2,
  input  logic [31:0]      rs2alu_opr1,
  input  logic [31:0]      rs2alu_opr2,
  input  logic [ROB_W-1:0] rs2alu_dependency,
  output logic             alu_valid,
  output logic [31:0]      alu_value,
  output logic [ROB_W-1:0] alu_dependency,
  output logic             alu_busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [31:0] mul_q, dq, dr, dd;
  logic [ROB_W-1:0] tag_q;
  logic neg_q, neg_r, want_rem;
  logic [2:0] f3;
  logic m_ext, div_sgn, dz, ovf, neg1, neg2, sa, sb;
  logic [4:0] sh;
  logic [31:0] a, b, sra, base_res, mul_word, abs1, abs2, byp_res, q_nx, r_nx, fix_res;
  logic [63:0] prod;
  logic [32:0] trial;
  assign a = rs2alu_opr1;
  assign b = rs2alu_opr2;
  assign f3 = rs2alu_op_L1[2:0];
  assign m_ext = rs2alu_op_L1[3];
  assign sh = b[4:0];
  assign sra = $signed(a) >>> sh;
  always_comb begin
    base_res = '0;
    case (f3)
      3'd0: base_res = rs2alu_op_L2 ? a - b : a + b;
      3'd1: base_res = a << sh;
      3'd2: base_res = {31'd0, $signed(a) < $signed(b)};
      3'd3: base_res = {31'd0, a < b};
      3'd4: base_res = a ^ b;
      3'd5: base_res = rs2alu_op_L2 ? sra : a >> sh;
      3'd6: base_res = a | b;
      default: base_res = a & b;
    endcase
  end
  // sign-extend only the operands the funct3 treats as signed; the low 64 bits of the product are then exact
  assign sa = (f3 == 3'd1) || (f3 == 3'd2);
  assign sb = f3 == 3'd1;
  assign prod = {{32{sa & a[31]}}, a} * {{32{sb & b[31]}}, b};
  assign mul_word = f3 == 3'd0 ? prod[31:0] : prod[63:32];
  assign div_sgn = ~f3[0];
  assign neg1 = div_sgn & a[31];
  assign neg2 = div_sgn & b[31];
  assign abs1 = neg1 ? -a : a;
  assign abs2 = neg2 ? -b : b;
  assign dz = b == '0;
  assign ovf = div_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  assign byp_res = dz ? (f3[1] ? a : 32'hFFFF_FFFF) : (f3[1] ? 32'h0 : 32'h8000_0000);
  // restoring step: dq shifts the dividend out at the top and the quotient in at the bottom
  assign trial = {dr, dq[31]} - {1'b0, dd};
  assign q_nx = {dq[30:0], ~trial[32]};
  assign r_nx = trial[32] ? {dr[30:0], dq[31]} : trial[31:0];
  assign fix_res = want_rem ? (neg_r ? -r_nx : r_nx) : (neg_q ? -q_nx : q_nx);
  assign alu_busy = state != IDLE;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt <= '0;
      alu_valid <= 1'b0;
      alu_value <= '0;
      alu_dependency <= '0;
      mul_q <= '0;
      dq <= '0;
      dr <= '0;
      dd <= '0;
      tag_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      want_rem <= 1'b0;
    end else if (rdy_in) begin
      alu_valid <= 1'b0;
      if (need_flush_in) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        if (rs2alu_ready) begin
          tag_q <= rs2alu_dependency;
          if (!m_ext || (f3[2] && (dz || ovf))) begin
            alu_valid <= 1'b1;
            alu_value <= m_ext ? byp_res : base_res;
            alu_dependency <= rs2alu_dependency;
          end else if (!f3[2]) begin
            state <= MUL;
            mul_q <= mul_word;
          end else begin
            state <= DIV;
            cnt <= 5'd31;
            dq <= abs1;
            dr <= '0;
            dd <= abs2;
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
            want_rem <= f3[1];
          end
        end
      end else if (state == MUL) begin
        state <= IDLE;
        alu_valid <= 1'b1;
        alu_value <= mul_q;
        alu_dependency <= tag_q;
      end else begin
        dq <= q_nx;
        dr <= r_nx;
        cnt <= cnt - 5'd1;
        if (cnt == 5'd0) begin
          state <= IDLE;
          alu_valid <= 1'b1;
          alu_value <= fix_res;
          alu_dependency <= tag_q;
        end
      end
    end
  end
endmodule
